// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   Fetch stage of the pipelined MIPS core. Holds the PC, captures the
//   instruction returned by program memory into the IF/ID register together
//   with PC+4, selects the next PC (sequential / branch / jump / jump-register),
//   applies stall and redirect flush, and flags bad fetch targets.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   Stall             hold PC and IF/ID
//   BranchTaken/Target, JumpTaken/Target, JRTaken/Target
//                     redirect requests; priority JR > Jump > Branch
//   Instruction       combinational read data from program memory at PC
//   PC                current fetch address (program memory address)
//   IFID_Instruction  registered instruction (0 on bubble)
//   IFID_PCPlus4      registered PC+4 of that instruction (0 on bubble)
//   IFID_Valid        IF/ID holds a real instruction
//   AddrError         sticky: misaligned target or PC outside memory window
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
    parameter int                    MEMORY_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  JumpTaken,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    input  logic                  JRTaken,
    input  logic [DATA_WIDTH-1:0] JRTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  AddrError
);

    // Window bounds carry one extra bit so the exclusive upper bound cannot
    // wrap when RESET_PC sits near the top of the address space.
    localparam logic [DATA_WIDTH:0] WIN_LO = {1'b0, RESET_PC};
    localparam logic [DATA_WIDTH:0] WIN_HI = WIN_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH:0]   next_ext;
    logic                  load;
    logic                  addr_fault;

    always_comb begin
        redirect   = JRTaken | JumpTaken | BranchTaken;
        target     = JRTaken   ? JRTarget   :
                     JumpTaken ? JumpTarget : BranchTarget;
        pc_plus4   = PC + DATA_WIDTH'(4);
        next_pc    = PC;
        load       = 1'b0;
        if (redirect) begin
            next_pc = {target[DATA_WIDTH-1:2], 2'b00};
            load    = 1'b1;
        end else if (!Stall) begin
            next_pc = pc_plus4;
            load    = 1'b1;
        end
        next_ext   = {1'b0, next_pc};
        // A held PC was already checked on the edge that loaded it.
        addr_fault = (redirect && (target[1:0] != 2'b00)) ||
                     (load && ((next_ext < WIN_LO) || (next_ext >= WIN_HI)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC               <= RESET_PC;
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
            AddrError        <= 1'b0;
        end else begin
            PC <= next_pc;
            if (addr_fault) begin
                AddrError <= 1'b1;
            end
            if (redirect) begin
                // The word fetched this cycle is on the wrong path: bubble.
                IFID_Instruction <= '0;
                IFID_PCPlus4     <= '0;
                IFID_Valid       <= 1'b0;
            end else if (!Stall) begin
                IFID_Instruction <= Instruction;
                IFID_PCPlus4     <= pc_plus4;
                IFID_Valid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        JumpTaken = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        JRTaken = 1'b0;
    logic [31:0] JRTarget = '0;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        AddrError;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .JumpTaken        (JumpTaken),
        .JumpTarget       (JumpTarget),
        .JRTaken          (JRTaken),
        .JRTarget         (JRTarget),
        .Instruction      (Instruction),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .AddrError        (AddrError)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0040_0000: return 32'h2008_0001;
            32'h0040_0004: return 32'h2009_0002;
            32'h0040_0008: return 32'h0109_5020;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    assign Instruction = mem_word(PC);

    function automatic logic in_window(input logic [31:0] a);
        return (a >= 32'h0040_0000) && (a < 32'h0040_1000);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    PC,               32'h0040_0000);
        check({tag, "_inst"},  IFID_Instruction, 32'h0);
        check({tag, "_pc4"},   IFID_PCPlus4,     32'h0);
        check({tag, "_valid"}, {31'b0, IFID_Valid}, 32'h0);
        check({tag, "_err"},   {31'b0, AddrError},  32'h0);
    endtask

    task automatic model_reset();
        m_pc = 32'h0040_0000; m_inst = '0; m_pc4 = '0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    // Enter just after a falling edge; reset asserted, checked without any
    // clock edge, released on the next falling edge.
    task automatic apply_reset(input string tag);
        Stall = 0; BranchTaken = 0; JumpTaken = 0; JRTaken = 0;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cycle(input logic st,
                         input logic bt, input logic [31:0] btg,
                         input logic jt, input logic [31:0] jtg,
                         input logic rt, input logic [31:0] rtg);
        exp_t e;
        logic [31:0] tgt;
        Stall = st; BranchTaken = bt; BranchTarget = btg;
        JumpTaken = jt; JumpTarget = jtg; JRTaken = rt; JRTarget = rtg;
        tgt = rt ? rtg : (jt ? jtg : btg);
        if (rt | jt | bt) begin
            m_pc = {tgt[31:2], 2'b00};
            m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
            if (tgt[1:0] != 2'b00 || !in_window(m_pc)) m_err = 1'b1;
        end else if (!st) begin
            m_inst  = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            if (!in_window(m_pc)) m_err = 1'b1;
        end
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.err = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_pc",    PC,               e.pc);
        check("sb_inst",  IFID_Instruction, e.inst);
        check("sb_pc4",   IFID_PCPlus4,     e.pc4);
        check("sb_valid", {31'b0, IFID_Valid}, {31'b0, e.valid});
        check("sb_err",   {31'b0, AddrError},  {31'b0, e.err});
        @(negedge clk);
        Stall = 0; BranchTaken = 0; JumpTaken = 0; JRTaken = 0;
    endtask

    task automatic seq();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic stall();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #2;
        apply_reset("reset");

        // sequential fetch
        seq();
        check("seq1_inst", IFID_Instruction, 32'h2008_0001);
        check("seq1_pc4",  IFID_PCPlus4,     32'h0040_0004);
        seq();
        check("seq2_inst", IFID_Instruction, 32'h2009_0002);
        check("seq2_pc",   PC,               32'h0040_0008);

        // stall two edges at PC 0x00400008
        stall();
        stall();
        check("stall_pc",   PC,               32'h0040_0008);
        check("stall_inst", IFID_Instruction, 32'h2009_0002);
        seq();
        check("resume_inst", IFID_Instruction, 32'h0109_5020);
        check("resume_pc4",  IFID_PCPlus4,     32'h0040_000C);
        check("resume_pc",   PC,               32'h0040_000C);

        // glitch between edges has no effect
        JumpTaken = 1'b1; JumpTarget = 32'h0040_0500;
        #2;
        JumpTaken = 1'b0;
        seq();
        check("glitch_pc", PC, 32'h0040_0010);

        // all redirects plus stall: JR wins
        cycle(1'b1, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0300);
        check("prio_pc",    PC,                  32'h0040_0300);
        check("prio_valid", {31'b0, IFID_Valid}, 32'h0);
        seq();
        check("prio_inst",  IFID_Instruction,    mem_word(32'h0040_0300));
        check("prio_valid2", {31'b0, IFID_Valid}, 32'h1);

        // jump over branch, misaligned target
        cycle(1'b0, 1'b1, 32'h0040_0800, 1'b1, 32'h0040_0102, 1'b0, 32'h0);
        check("mis_pc",  PC,                 32'h0040_0100);
        check("mis_err", {31'b0, AddrError}, 32'h1);
        seq();
        seq();
        check("mis_sticky", {31'b0, AddrError}, 32'h1);
        apply_reset("reset2");

        // branch to exclusive upper bound
        seq();
        cycle(1'b0, 1'b1, 32'h0040_1000, 1'b0, 32'h0, 1'b0, 32'h0);
        check("oow_pc",  PC,                 32'h0040_1000);
        check("oow_err", {31'b0, AddrError}, 32'h1);
        seq();
        stall();
        check("oow_sticky", {31'b0, AddrError}, 32'h1);
        apply_reset("reset3");

        // sequential walk off the top of the window
        cycle(1'b0, 1'b1, 32'h0040_0FF8, 1'b0, 32'h0, 1'b0, 32'h0);
        seq();
        check("edge_in_err", {31'b0, AddrError}, 32'h0);
        check("edge_in_pc",  PC,                 32'h0040_0FFC);
        seq();
        check("edge_out_pc",  PC,                 32'h0040_1000);
        check("edge_out_err", {31'b0, AddrError}, 32'h1);
        seq();
        check("edge_sticky", {31'b0, AddrError}, 32'h1);
        apply_reset("reset4");

        // PC+4 wraps modulo 2^32
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        seq();
        check("wrap_pc",  PC,           32'h0);
        check("wrap_pc4", IFID_PCPlus4, 32'h0);
        apply_reset("reset5");

        // async reset mid-stall with a valid IF/ID
        seq();
        seq();
        check("pre_async_valid", {31'b0, IFID_Valid}, 32'h1);
        Stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        check_reset_outputs("async_hold");
        @(negedge clk);
        reset = 1'b1;
        Stall = 1'b0;
        seq();
        check("post_async_inst", IFID_Instruction, 32'h2008_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the pipelined MIPS core.
- Holds the program counter and drives it to the program memory address input.
- Captures the combinational instruction returned by the program memory, together with PC+4, into the IF/ID pipeline register.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Applies stall (hold) and redirect flush (bubble).
- Flags fetch targets that are misaligned or outside the program memory window.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC and instruction.
- RESET_PC, 32'h0040_0000, PC value after reset; also the base of the program memory window.
- MEMORY_DEPTH, 1024, number of program memory words; the window is [RESET_PC, RESET_PC+4*MEMORY_DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit request to hold PC and IF/ID.
- BranchTaken  in  1  branch resolved taken.
- BranchTarget  in  DATA_WIDTH  branch target address.
- JumpTaken  in  1  J/JAL taken.
- JumpTarget  in  DATA_WIDTH  jump target address.
- JRTaken  in  1  JR taken.
- JRTarget  in  DATA_WIDTH  register target address.
- Instruction  in  DATA_WIDTH  combinational read data from program memory.
- PC  out  DATA_WIDTH  current fetch address, wired to the program memory Address input.
- IFID_Instruction  out  DATA_WIDTH  registered instruction.
- IFID_PCPlus4  out  DATA_WIDTH  registered PC+4 of that instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- AddrError  out  1  sticky fetch-address error flag.

## Operation
Redirect = JRTaken | JumpTaken | BranchTaken.

Target priority: JR > Jump > Branch. Simultaneous requests use the highest priority target only.

Per rising edge, in priority order:
1. reset low (async, any time, including mid-stall): PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, AddrError=0.
2. Redirect (overrides Stall):
   - PC = selected target with bits [1:0] forced to 00.
   - IF/ID flushed: IFID_Instruction=0 (NOP), IFID_PCPlus4=0, IFID_Valid=0.
3. Stall without redirect: PC, IFID_Instruction, IFID_PCPlus4 and IFID_Valid all hold their values.
4. Otherwise:
   - PC = PC+4.
   - IFID_Instruction = Instruction.
   - IFID_PCPlus4 = PC+4.
   - IFID_Valid = 1.

Arithmetic and address rules:
- PC+4 is computed modulo 2^DATA_WIDTH. Wrap from 32'hFFFF_FFFC to 0 is permitted and raises AddrError, because 0 lies outside the window.
- AddrError sets on any edge where the newly loaded PC is outside the window, or where the selected redirect target has a nonzero bits [1:0].
- AddrError clears only on reset. Fetch continues normally after it is set; the flag is diagnostic only.
- The window check uses full-width unsigned comparison. The upper bound is exclusive: RESET_PC+4*MEMORY_DEPTH is out of window.

## Timing
- PC is a registered output. Program memory returns Instruction combinationally in the same cycle; it is captured at the next rising edge.
- Fetch latency: the instruction at address A appears on IFID_Instruction one edge after PC=A, provided no stall or redirect occurs on that edge.
- Redirect penalty: exactly one bubble. The instruction fetched during the redirect cycle is discarded, and the target instruction is valid in IF/ID two edges after redirect assertion.
- Stall of N cycles holds outputs for N edges. The first non-stalled edge resumes with the held PC.
- Inputs Stall, *Taken and *Target are sampled only at the rising edge. Glitches between edges have no effect.
- First edge after reset release: PC becomes RESET_PC+4 and IF/ID holds the instruction at RESET_PC with Valid=1, unless Stall or a redirect is asserted.

## Test plan
- Reset and sequential fetch: release reset, with program memory words 0x20080001, 0x20090002, 0x01095020. After 3 edges, IF/ID has shown those words in order with IFID_PCPlus4 = 0x00400004, 0x00400008, 0x0040000C; PC=0x0040000C; AddrError=0.
- Stall: assert Stall for 2 edges while PC=0x00400008. PC and IF/ID hold for both edges. On release, IF/ID receives the word at 0x00400008 with PCPlus4 0x0040000C.
- Redirect priority with simultaneous stall: in one cycle assert BranchTaken (0x00400100), JumpTaken (0x00400200), JRTaken (0x00400300) and Stall. Next edge: PC=0x00400300, IFID_Valid=0, IFID_Instruction=0. The following edge: IF/ID holds the word at 0x00400300 with Valid=1.
- Misaligned and out-of-window target: JumpTaken with target 0x00400102 loads PC=0x00400100 and sets AddrError. A separate run with BranchTarget 0x00401000 sets AddrError and PC=0x00401000. A further run with a sequential fetch from PC=0x00400FFC, which loads 0x00401000, also sets AddrError. In all three cases AddrError stays set until reset.
- Async reset mid-operation: drop reset between edges while Stall=1 and IFID_Valid=1. All outputs go to reset values immediately, without waiting for a clock edge, and stay there until reset rises.
